// File: rtl/seg7_pkg.sv
// Purpose: shared seven-segment constants for the BCD display scan driver.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Segment patterns are active-high, bit0 = a ... bit6 = g.
package seg7_pkg;

  localparam int BCD_W = 4;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_OFF   = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// Purpose: decode one BCD digit to an active-high seven-segment pattern.
// Latency: combinational.
// Backpressure: none.
// Ports: bcd (4-bit digit in), seg (7-bit pattern out, codes 10-15 show a minus sign).
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [6:0]       seg
);

  always_comb begin
    seg = SEG_MINUS;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_MINUS;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scan_driver.sv
// Purpose: snapshot packed BCD digits and time-multiplex them onto one 7-seg display.
// Latency: outputs registered, 1 cycle after (index, prescaler, snapshot) state.
// Backpressure: none; load is sampled every edge, scanning free-runs.
// Ports: clk/reset (async high), bcd_in/dp_in snapshot on load, blank_lz level,
//        seg/dp/an to the pins (polarity by parameter), frame_done pulse per full scan.
module bcd_seg_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 100000,
  parameter int BLANK_CYCLES   = 1,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [BCD_W*DIGITS-1:0] bcd_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic [DIGITS-1:0]       dp_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [DIGITS-1:0]       an,
  output logic                    frame_done
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [PW-1:0]     PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0]     BLANK_END  = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [6:0]        SEG_IDLE   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic              DP_IDLE    = SEG_ACTIVE_LOW;
  localparam logic [DIGITS-1:0] AN_IDLE    = AN_ACTIVE_LOW ? '1 : '0;

  logic [BCD_W*DIGITS-1:0] snap_q, snap_d;
  logic [DIGITS-1:0]       dp_snap_q, dp_snap_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    frame_done_q, frame_done_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [DIGITS-1:0]       an_q, an_d;

  logic                    tick;
  logic [BCD_W-1:0]        cur_bcd;
  logic                    cur_dp;
  logic [6:0]              cur_pat;
  logic                    zeros_above;
  logic                    lz_blank;
  logic [DIGITS-1:0]       an_onehot;

  // Counters and snapshot. A load on a tick edge lands together with the
  // index advance, so the new slot decodes the freshly captured value.
  always_comb begin
    tick         = (presc_q == PRESC_LAST);
    snap_d       = load ? bcd_in : snap_q;
    dp_snap_d    = load ? dp_in : dp_snap_q;
    presc_d      = tick ? '0 : presc_q + PW'(1);
    idx_d        = idx_q;
    frame_done_d = 1'b0;
    if (tick) begin
      idx_d        = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      frame_done_d = (idx_q == IDX_LAST);
    end
  end

  // Digit mux and leading-zero detection. Walking from the most significant
  // digit down, zeros_above stays set only while every digit so far is 0.
  always_comb begin
    cur_bcd     = '0;
    cur_dp      = 1'b0;
    zeros_above = 1'b1;
    lz_blank    = 1'b0;
    an_onehot   = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (i > 0) begin
        zeros_above = zeros_above & (snap_q[i*BCD_W +: BCD_W] == '0);
      end
      if (idx_q == IW'(i)) begin
        cur_bcd      = snap_q[i*BCD_W +: BCD_W];
        cur_dp       = dp_snap_q[i];
        an_onehot[i] = 1'b1;
        lz_blank     = (i > 0) && blank_lz && zeros_above;
      end
    end
  end

  bcd_to_seg7 u_dec (
    .bcd (cur_bcd),
    .seg (cur_pat)
  );

  // Output stage: seg/dp keep showing the digit through the anti-ghost window,
  // only the anode is held off.
  always_comb begin
    seg_d = (lz_blank ? SEG_OFF : cur_pat) ^ {7{SEG_ACTIVE_LOW}};
    dp_d  = cur_dp ^ SEG_ACTIVE_LOW;
    an_d  = ((presc_q < BLANK_END) ? '0 : an_onehot) ^ {DIGITS{AN_ACTIVE_LOW}};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_q       <= '0;
      dp_snap_q    <= '0;
      presc_q      <= '0;
      idx_q        <= '0;
      frame_done_q <= 1'b0;
      seg_q        <= SEG_IDLE;
      dp_q         <= DP_IDLE;
      an_q         <= AN_IDLE;
    end else begin
      snap_q       <= snap_d;
      dp_snap_q    <= dp_snap_d;
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      frame_done_q <= frame_done_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_seg_scan_driver.sv
// Purpose: scoreboard bench for bcd_seg_scan_driver (4 digits, 4-cycle slots, 1 blank cycle, active-low pins).
// Latency: expected slot contents are queued at load time and popped at each slot's first lit cycle.
// Backpressure: n/a.
module tb_bcd_seg_scan_driver;

  logic        clk;
  logic        reset;
  logic [15:0] bcd_in;
  logic        load;
  logic        blank_lz;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int passed = 0;
  int total  = 0;
  int cyc;
  int last_fd;
  int fd_count = 0;

  // Each entry: {an[3:0], seg[6:0], dp} expected for one digit slot.
  logic [11:0] exp_q[$];
  logic [11:0] cur;
  logic        have_exp;
  logic [3:0]  prev_an;

  bcd_seg_scan_driver #(
    .DIGITS         (4),
    .REFRESH_DIV    (4),
    .BLANK_CYCLES   (1),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bcd_in     (bcd_in),
    .load       (load),
    .blank_lz   (blank_lz),
    .dp_in      (dp_in),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: compare every lit cycle of a slot against the entry popped at
  // the slot's first lit cycle; track frame_done spacing.
  always @(negedge clk) begin
    if (reset) begin
      prev_an  = 4'hF;
      have_exp = 1'b0;
      last_fd  = 0;
    end else begin
      if (frame_done) begin
        check("frame_done_interval", cyc - last_fd, 16);
        last_fd = cyc;
        fd_count++;
      end
      if (an != 4'hF) begin
        if (prev_an == 4'hF) begin
          if (exp_q.size() > 0) begin
            cur      = exp_q.pop_front();
            have_exp = 1'b1;
          end else begin
            have_exp = 1'b0;
          end
        end
        if (have_exp) begin
          check("slot_an",  int'(an),  int'(cur[11:8]));
          check("slot_seg", int'(seg), int'(cur[7:1]));
          check("slot_dp",  int'(dp),  int'(cur[0]));
        end
      end
      prev_an = an;
    end
  end

  // Park at the negedge just before a frame-start tick edge (edge 16m).
  task automatic wait_frame();
    int n = 0;
    @(negedge clk);
    while (((cyc + 1) % 16) != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("wait_frame_timeout", n, 0);
  endtask

  task automatic do_load(input logic [15:0] b, input logic [3:0] d, input logic blz);
    wait_frame();
    bcd_in = b;
    dp_in  = d;
    load   = 1'b1;
    @(negedge clk);
    load     = 1'b0;
    blank_lz = blz;
  endtask

  // segs = {d3,d2,d1,d0} pin-level patterns, dps = pin-level dp per digit.
  task automatic push_frames(input logic [27:0] segs, input logic [3:0] dps, input int nframes);
    for (int f = 0; f < nframes; f++) begin
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back({~(4'b0001 << i), segs[i*7 +: 7], dps[i]});
      end
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0;
    reset    = 1'b1;
    bcd_in   = '0;
    load     = 1'b0;
    blank_lz = 1'b0;
    dp_in    = '0;
    #1;
    check("reset_seg", int'(seg), 'h7F);
    check("reset_dp",  int'(dp),  1);
    check("reset_an",  int'(an),  'hF);
    check("reset_fd",  int'(frame_done), 0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;

    // Full scan of 4321, two frames.
    do_load(16'h4321, 4'b0000, 1'b0);
    push_frames({7'h19, 7'h30, 7'h24, 7'h79}, 4'b1111, 2);
    repeat (16) @(negedge clk);

    // Leading-zero blanking of 0050, then same snapshot with blanking off.
    do_load(16'h0050, 4'b0000, 1'b1);
    push_frames({7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111, 1);
    repeat (16) @(negedge clk);
    blank_lz = 1'b0;
    push_frames({7'h40, 7'h40, 7'h12, 7'h40}, 4'b1111, 1);

    // All zeros blanked: digit 0 stays lit, blanked digit 3 keeps its dp.
    do_load(16'h0000, 4'b1000, 1'b1);
    push_frames({7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0111, 1);

    // Invalid code on digit 2 with its dp lit.
    do_load(16'h7B85, 4'b0100, 1'b0);
    push_frames({7'h78, 7'h3F, 7'h00, 7'h12}, 4'b1011, 1);

    // All invalid codes show minus.
    do_load(16'hAFCE, 4'b0000, 1'b0);
    push_frames({7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b1111, 1);

    // Reset in the middle of digit 2's slot.
    do_load(16'h1234, 4'b0000, 1'b0);
    exp_q.push_back({4'hE, 7'h19, 1'b1});
    exp_q.push_back({4'hD, 7'h30, 1'b1});
    exp_q.push_back({4'hB, 7'h24, 1'b1});
    repeat (11) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_seg", int'(seg), 'h7F);
    check("midrst_dp",  int'(dp),  1);
    check("midrst_an",  int'(an),  'hF);
    check("midrst_fd",  int'(frame_done), 0);
    check("midrst_q_empty", exp_q.size(), 0);
    push_frames({7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111, 1);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("rel_cycle1_an", int'(an), 'hF);
    @(negedge clk);
    check("rel_cycle2_an",  int'(an),  'hE);
    check("rel_cycle2_seg", int'(seg), 'h40);

    // Load 9999 on the tick edge that moves digit 0 -> 1.
    do_load(16'h0000, 4'b0000, 1'b0);
    exp_q.push_back({4'hE, 7'h40, 1'b1});
    repeat (3) @(negedge clk);
    bcd_in = 16'h9999;
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
    exp_q.push_back({4'hD, 7'h10, 1'b1});
    exp_q.push_back({4'hB, 7'h10, 1'b1});
    exp_q.push_back({4'h7, 7'h10, 1'b1});

    // bcd_in wanders with load low: display holds 6060.
    do_load(16'h6060, 4'b0000, 1'b0);
    push_frames({7'h02, 7'h40, 7'h02, 7'h40}, 4'b1111, 2);
    #1 fd0 = fd_count;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      bcd_in = 16'h1111 * (k % 10);
    end
    #1 check("fd_pulses_32cyc", fd_count - fd0, 2);
    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
